icache_next_line_prefetcher: RTL and testbench

- Next-line prefetch engine that sits directly upstream of the I-cache register arrays (tag, valid, data).
- Drives the arrays' prefetch-side lookup/write port (next_set/pref_set, next_load, next_datain) and consumes next_dataout for its tag check.
- After each demand hit on line L, fetches line L+1 from physical memory and installs it, unless L+1 is already resident.
- Holds off the demand miss path through pf_busy while it owns memory.

---
 rtl/icache_next_line_prefetcher.sv | 131 +++++++++++++
 tb/tb_icache_next_line_prefetcher.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/icache_next_line_prefetcher.sv
// Next-line instruction prefetcher placed upstream of the I-cache tag/valid/data arrays.
// After each demand hit on line L, it looks up line L+1 through the prefetch-side array
// port. If that line is not resident, it fetches it from memory and installs it.
//
// Handshake: the memory read holds pmem_read and pmem_address steady until a one-cycle
// pmem_resp, which carries pmem_rdata. The array write (pf_load) is a single-cycle strobe
// with no back-pressure; it is only deferred while the demand side writes the same set.
module icache_next_line_prefetcher #(
  parameter int s_offset = 5,
  parameter int s_index  = 3,
  parameter int s_tag    = 32 - s_offset - s_index,
  parameter int s_line   = 8 * (2 ** s_offset)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                demand_valid,
  input  logic                demand_miss,
  input  logic [31:0]         demand_addr,
  input  logic                demand_load,
  input  logic [s_index-1:0]  demand_windex,
  output logic [s_index-1:0]  pf_set,
  input  logic [s_tag-1:0]    pf_tag_in,
  input  logic                pf_valid_in,
  output logic                pf_load,
  output logic [s_tag-1:0]    pf_tag_out,
  output logic                pf_valid_out,
  output logic [s_line-1:0]   pf_line_out,
  output logic                pmem_read,
  output logic [31:0]         pmem_address,
  input  logic                pmem_resp,
  input  logic [s_line-1:0]   pmem_rdata,
  output logic                pf_busy,
  output logic [15:0]         pf_count,
  output logic [1:0]          dbg_state
);

  typedef enum logic [1:0] {IDLE = 2'd0, CHECK = 2'd1, FETCH = 2'd2, FILL = 2'd3} state_t;

  localparam logic [31:0] LINE_MASK = (32'd1 << s_offset) - 32'd1;

  state_t              state_q;
  logic [31:0]         pf_addr_q;
  logic [31:0]         last_addr_q;
  logic                last_valid_q;
  logic [s_index-1:0]  pf_set_q;
  logic [s_tag-1:0]    tag_out_q;
  logic                valid_out_q;
  logic [s_line-1:0]   line_q;
  logic [31:0]         pmem_addr_q;
  logic [15:0]         count_q;

  logic [31:0]         cand_addr;
  logic                trigger;
  logic                resident;
  logic                conflict;

  // Setting the offset bits and adding one yields the next line base address, wrapping at 2^32.
  assign cand_addr = (demand_addr | LINE_MASK) + 32'd1;
  assign trigger   = demand_valid && !demand_miss && !(last_valid_q && (cand_addr == last_addr_q));
  assign resident  = pf_valid_in && (pf_tag_in == pf_addr_q[31 -: s_tag]);
  assign conflict  = demand_load && (demand_windex == pf_set_q);

  // Prefetch sequencing: trigger, tag check, memory fetch, then a single array write.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      pf_addr_q    <= '0;
      last_addr_q  <= '0;
      last_valid_q <= 1'b0;
      pf_set_q     <= '0;
      tag_out_q    <= '0;
      valid_out_q  <= 1'b0;
      line_q       <= '0;
      pmem_addr_q  <= '0;
      count_q      <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (trigger) begin
            pf_addr_q <= cand_addr;
            pf_set_q  <= cand_addr[s_offset +: s_index];
            state_q   <= CHECK;
          end
        end
        CHECK: begin
          if (demand_miss) begin
            // The demand side needs memory; drop this candidate without recording it.
            state_q <= IDLE;
          end else if (resident) begin
            last_addr_q  <= pf_addr_q;
            last_valid_q <= 1'b1;
            state_q      <= IDLE;
          end else begin
            pmem_addr_q <= pf_addr_q;
            state_q     <= FETCH;
          end
        end
        FETCH: begin
          if (pmem_resp) begin
            line_q      <= pmem_rdata;
            tag_out_q   <= pf_addr_q[31 -: s_tag];
            valid_out_q <= 1'b1;
            state_q     <= FILL;
          end
        end
        FILL: begin
          // Wait out any same-set demand write so the set is never written twice in one cycle.
          if (!conflict) begin
            if (count_q != 16'hFFFF) count_q <= count_q + 16'd1;
            last_addr_q  <= pf_addr_q;
            last_valid_q <= 1'b1;
            state_q      <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign pf_set       = pf_set_q;
  assign pf_tag_out   = tag_out_q;
  assign pf_valid_out = valid_out_q;
  assign pf_line_out  = line_q;
  assign pmem_address = pmem_addr_q;
  assign pf_count     = count_q;
  assign pmem_read    = (state_q == FETCH);
  assign pf_busy      = (state_q != IDLE);
  assign pf_load      = (state_q == FILL) && !conflict;
  assign dbg_state    = state_q;

endmodule

// File: tb/tb_icache_next_line_prefetcher.sv
// Directed bench for the next-line prefetcher. Installed lines are scoreboarded through
// exp_q, and every other value is checked at fixed points in the sequence.
module tb_icache_next_line_prefetcher;

  localparam int S_OFFSET = 5;
  localparam int S_INDEX  = 3;
  localparam int S_TAG    = 32 - S_OFFSET - S_INDEX;
  localparam int S_LINE   = 256;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic               demand_valid = 1'b0;
  logic               demand_miss  = 1'b0;
  logic [31:0]        demand_addr  = '0;
  logic               demand_load  = 1'b0;
  logic [S_INDEX-1:0] demand_windex = '0;
  logic [S_INDEX-1:0] pf_set;
  logic [S_TAG-1:0]   pf_tag_in = '0;
  logic               pf_valid_in = 1'b0;
  logic               pf_load;
  logic [S_TAG-1:0]   pf_tag_out;
  logic               pf_valid_out;
  logic [S_LINE-1:0]  pf_line_out;
  logic               pmem_read;
  logic [31:0]        pmem_address;
  logic               pmem_resp = 1'b0;
  logic [S_LINE-1:0]  pmem_rdata = '0;
  logic               pf_busy;
  logic [15:0]        pf_count;
  logic [1:0]         dbg_state;

  icache_next_line_prefetcher dut (
    .clk(clk), .rst(rst),
    .demand_valid(demand_valid), .demand_miss(demand_miss), .demand_addr(demand_addr),
    .demand_load(demand_load), .demand_windex(demand_windex),
    .pf_set(pf_set), .pf_tag_in(pf_tag_in), .pf_valid_in(pf_valid_in),
    .pf_load(pf_load), .pf_tag_out(pf_tag_out), .pf_valid_out(pf_valid_out),
    .pf_line_out(pf_line_out), .pmem_read(pmem_read), .pmem_address(pmem_address),
    .pmem_resp(pmem_resp), .pmem_rdata(pmem_rdata), .pf_busy(pf_busy),
    .pf_count(pf_count), .dbg_state(dbg_state)
  );

  int total = 0;
  int bad   = 0;
  logic [S_LINE-1:0] exp_q[$];

  task automatic check(input string tag, input logic [S_LINE-1:0] got, input logic [S_LINE-1:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got[63:0], exp[63:0]);
    end
  endtask

  // driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic hit(input logic [31:0] addr);
    demand_valid = 1'b1;
    demand_addr  = addr;
    step();
    demand_valid = 1'b0;
  endtask

  // scoreboard: every array write must match the next expected line
  always @(negedge clk) begin
    if (!rst && pf_load) begin
      if (exp_q.size() == 0) check("unexpected_load", 1, 0);
      else check("fill_line", pf_line_out, exp_q.pop_front());
      check("load_busy", pf_busy, 1);
    end
  end

  logic [S_LINE-1:0] d1, d2, d3;

  initial begin
    d1 = {8{32'hA5A5_0001}};
    d2 = {8{32'h1234_5678}} ^ 256'h3;
    d3 = {4{64'hDEAD_BEEF_0BAD_F00D}};

    // reset then idle
    step(); step();
    rst = 1'b0;
    step();
    check("rst_load", pf_load, 0);
    check("rst_read", pmem_read, 0);
    check("rst_busy", pf_busy, 0);
    check("rst_count", pf_count, 0);
    check("rst_addr", pmem_address, 0);
    step(); step(); step();
    check("idle_busy", pf_busy, 0);
    check("idle_state", dbg_state, 0);

    // demand miss in IDLE never triggers
    demand_miss = 1'b1;
    hit(32'h0000_0040);
    demand_miss = 1'b0;
    check("miss_no_trigger", pf_busy, 0);

    // hit at 0x40, line 0x60 absent -> fetch and fill
    pf_valid_in = 1'b0;
    hit(32'h0000_0040);
    check("t1_check_state", dbg_state, 1);
    check("t1_check_set", pf_set, 3);
    check("t1_check_noread", pmem_read, 0);
    step();
    check("t1_read", pmem_read, 1);
    check("t1_addr", pmem_address, 32'h60);
    step();
    check("t1_read_held", pmem_read, 1);
    check("t1_addr_held", pmem_address, 32'h60);
    pmem_resp = 1'b1; pmem_rdata = d1; exp_q.push_back(d1);
    step();
    pmem_resp = 1'b0;
    check("t1_load", pf_load, 1);
    check("t1_read_drop", pmem_read, 0);
    check("t1_set", pf_set, 3);
    check("t1_tag", pf_tag_out, 0);
    check("t1_valid", pf_valid_out, 1);
    step();
    check("t1_load_done", pf_load, 0);
    check("t1_idle", pf_busy, 0);
    check("t1_count", pf_count, 1);

    // hit at 0x100, line 0x120 resident (set 1, tag 1)
    pf_valid_in = 1'b1; pf_tag_in = 24'd1;
    hit(32'h0000_0100);
    check("t2_set", pf_set, 1);
    check("t2_busy", pf_busy, 1);
    step();
    check("t2_idle", pf_busy, 0);
    check("t2_noread", pmem_read, 0);
    hit(32'h0000_0104);
    check("t2_filtered", pf_busy, 0);
    check("t2_count", pf_count, 1);

    // fill conflict: hit 0x200 -> line 0x220, set 1, tag 2
    pf_valid_in = 1'b0; pf_tag_in = '0;
    hit(32'h0000_0200);
    step();
    check("t3_read", pmem_read, 1);
    check("t3_addr", pmem_address, 32'h220);
    pmem_resp = 1'b1; pmem_rdata = d2; exp_q.push_back(d2);
    demand_load = 1'b1; demand_windex = 3'd1;
    step();
    pmem_resp = 1'b0;
    check("t3_stall0", pf_load, 0);
    step();
    check("t3_stall1", pf_load, 0);
    step();
    check("t3_stall2", pf_load, 0);
    check("t3_stall_state", dbg_state, 3);
    demand_load = 1'b0;
    #1;
    check("t3_load", pf_load, 1);
    check("t3_tag", pf_tag_out, 2);
    step();
    check("t3_idle", pf_busy, 0);
    check("t3_count", pf_count, 2);

    // wrap: 0xFFFFFFE4 -> line 0, set 0, tag 0
    hit(32'hFFFF_FFE4);
    check("t4_set", pf_set, 0);
    step();
    check("t4_read", pmem_read, 1);
    check("t4_addr", pmem_address, 32'h0);
    pmem_resp = 1'b1; pmem_rdata = d3; exp_q.push_back(d3);
    step();
    pmem_resp = 1'b0;
    check("t4_load", pf_load, 1);
    check("t4_tag", pf_tag_out, 0);
    step();
    check("t4_count", pf_count, 3);

    // demand miss during CHECK aborts without recording the candidate
    hit(32'h0000_0400);
    check("t5_check", dbg_state, 1);
    demand_miss = 1'b1;
    step();
    demand_miss = 1'b0;
    check("t5_idle", pf_busy, 0);
    check("t5_noread", pmem_read, 0);
    pf_valid_in = 1'b1; pf_tag_in = 24'd4;
    hit(32'h0000_0400);
    check("t5_retrigger", pf_busy, 1);
    step();
    check("t5_resident_idle", pf_busy, 0);

    // reset in the middle of FETCH
    pf_valid_in = 1'b0; pf_tag_in = '0;
    hit(32'h0000_0800);
    step();
    check("t6_read", pmem_read, 1);
    rst = 1'b1;
    step();
    check("t6_read_drop", pmem_read, 0);
    check("t6_busy", pf_busy, 0);
    check("t6_state", dbg_state, 0);
    check("t6_count", pf_count, 0);
    rst = 1'b0;
    pmem_resp = 1'b1; pmem_rdata = d1;
    step();
    pmem_resp = 1'b0;
    step(); step();
    check("t6_no_load", pf_load, 0);
    check("t6_idle", pf_busy, 0);
    check("exp_q_empty", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
